input_interface: RTL

Receive-side counterpart of the SHA-3 output interface. Accepts a 1600-bit Keccak state as eight indexed 200-bit beats, reassembles it in the same bit order the output interface uses to serialize, and presents the complete block plus its tag to the permutation core. The block has one assembly register and one holding register, so the next block can stream in while the core has not yet taken the current one. Out-of-order beats are flagged and drive a resynchronization.

---
 rtl/input_interface.sv | 104 ++++++++++
 1 files changed

// File: rtl/input_interface.sv
// Receive side of the SHA-3 block link: reassembles eight indexed 200-bit beats into a
// 1600-bit state, with one assembly register and one holding register toward the core.
module input_interface #(
    parameter int TAGW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pushin,
    input  logic [2:0]       dinix,
    input  logic [199:0]     din,
    input  logic [TAGW-1:0]  tagin,
    output logic             stopout,
    output logic [1599:0]    dout,
    output logic [TAGW-1:0]  tagout,
    output logic             pushout,
    input  logic             stopin,
    output logic             err
);

    localparam int BEAT_W  = 200;
    localparam int BLOCK_W = 1600;

    typedef enum logic {FILL, FULL} state_t;

    state_t                    state;
    logic [2:0]                expix;
    logic [BLOCK_W-1:0]        asm_p0;
    logic [TAGW-1:0]           asm_tag_p0;

    logic offered;
    logic accept;
    logic resync;
    logic hold_free;
    logic load_fill;
    logic load_full;

    assign stopout   = (state == FULL);
    assign offered   = pushin && !stopout;
    assign accept    = offered && (dinix == expix);
    assign resync    = offered && (dinix != expix) && (dinix == 3'd0);
    assign hold_free = !pushout || !stopin;
    assign load_fill = accept && (expix == 3'd7) && hold_free;
    assign load_full = (state == FULL) && hold_free;

    // Assembly register: data only, no reset needed since expix gates its use
    always_ff @(posedge clk) begin
        if (accept || resync) begin
            asm_p0[BEAT_W*int'(dinix) +: BEAT_W] <= din;
            if (dinix == 3'd0) begin
                asm_tag_p0 <= tagin;
            end
        end
    end

    // Holding register and control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FILL;
            expix   <= 3'd0;
            pushout <= 1'b0;
            dout    <= '0;
            tagout  <= '0;
            err     <= 1'b0;
        end else begin
            err <= (pushin && stopout) || (offered && (dinix != expix));

            // Beat 7 bypasses the assembly register so the block reaches hold on the same edge
            if (load_fill) begin
                dout    <= {din, asm_p0[BLOCK_W-BEAT_W-1:0]};
                tagout  <= asm_tag_p0;
                pushout <= 1'b1;
            end else if (load_full) begin
                dout    <= asm_p0;
                tagout  <= asm_tag_p0;
                pushout <= 1'b1;
            end else if (!stopin) begin
                pushout <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (accept) begin
                        expix <= 3'(expix + 3'd1);
                        if ((expix == 3'd7) && !hold_free) begin
                            state <= FULL;
                        end
                    end else if (resync) begin
                        expix <= 3'd1;
                    end else if (offered) begin
                        expix <= 3'd0;
                    end
                end
                FULL: begin
                    if (hold_free) begin
                        state <= FILL;
                        expix <= 3'd0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
